// File: rtl/bomb_pkg.sv
// Shared constants and helpers for the bomb map: geometry, cell states, indexing.
package bomb_pkg;

  localparam int unsigned MAP_DIM   = 10;
  localparam int unsigned NUM_CELLS = MAP_DIM * MAP_DIM;
  localparam int unsigned COORD_MIN = 1;
  localparam int unsigned COORD_MAX = 8;

  typedef enum logic [1:0] {
    CELL_EMPTY   = 2'd0,
    CELL_FRESH   = 2'd1,
    CELL_FUSED   = 2'd2,
    CELL_EXPLODE = 2'd3
  } cell_e;

  function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] v;
    v = 8'(x) * 8'd10 + 8'(y);
    return v[6:0];
  endfunction

  function automatic logic coord_ok(input logic [3:0] c);
    return (c >= 4'(COORD_MIN)) && (c <= 4'(COORD_MAX));
  endfunction

  function automatic logic [NUM_CELLS-1:0] playable_mask();
    logic [NUM_CELLS-1:0] m;
    m = '0;
    for (int x = COORD_MIN; x <= COORD_MAX; x++) begin
      for (int y = COORD_MIN; y <= COORD_MAX; y++) begin
        m[x*MAP_DIM+y] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [NUM_CELLS-1:0] PLAY_MASK = playable_mask();

endpackage

// File: rtl/bomb_placer_if.sv
// Player-facing control bundle: drop buttons, positions, game state, results.
interface bomb_placer_if;
  logic       i_dropA;
  logic       i_dropB;
  logic [3:0] playerAx;
  logic [3:0] playerAy;
  logic [3:0] playerBx;
  logic [3:0] playerBy;
  logic [1:0] game_state;
  logic [2:0] o_bombCountA;
  logic [2:0] o_bombCountB;
  logic       o_placeAckA;
  logic       o_placeAckB;
  logic       o_placeRejA;
  logic       o_placeRejB;

  modport master (
    output i_dropA, i_dropB, playerAx, playerAy, playerBx, playerBy, game_state,
    input  o_bombCountA, o_bombCountB, o_placeAckA, o_placeAckB, o_placeRejA, o_placeRejB
  );

  modport slave (
    input  i_dropA, i_dropB, playerAx, playerAy, playerBx, playerBy, game_state,
    output o_bombCountA, o_bombCountB, o_placeAckA, o_placeAckB, o_placeRejA, o_placeRejB
  );
endinterface

// File: rtl/drop_req.sv
// Drop-button rising-edge detector with a coalescing pending flag.
module drop_req (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  input  logic i_service,
  output logic o_req
);

  logic r_level;
  logic r_pending;
  logic w_edge;
  logic w_pending_n;

  // The live edge counts as a request in its own cycle so service is not delayed.
  always_comb begin
    w_edge      = i_level & ~r_level;
    o_req       = r_pending | w_edge;
    w_pending_n = i_service ? 1'b0 : o_req;
  end

  // Button copy resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level   <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_level   <= i_level;
      r_pending <= w_pending_n;
    end
  end

endmodule

// File: rtl/bomb_placer.sv
// Registered 10x10 bomb map; services drop requests and reloads the aged map on ticks.
module bomb_placer
  import bomb_pkg::*;
#(
  parameter int unsigned MAX_BOMBS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic [NUM_CELLS-1:0] i_updatedBombMap_0,
  input  logic [NUM_CELLS-1:0] i_updatedBombMap_1,
  output logic [NUM_CELLS-1:0] o_curBombMap_0,
  output logic [NUM_CELLS-1:0] o_curBombMap_1,
  bomb_placer_if.slave         bus
);

  logic [NUM_CELLS-1:0] r_map0;
  logic [NUM_CELLS-1:0] r_map1;
  logic [NUM_CELLS-1:0] r_owner;
  logic                 r_ackA, r_ackB, r_rejA, r_rejB;

  logic [NUM_CELLS-1:0] w_map0_n, w_map1_n, w_owner_n;
  logic                 w_reqA, w_reqB, w_svcA, w_svcB;
  logic                 w_validA, w_validB, w_emptyA, w_emptyB;
  logic                 w_accA, w_accB, w_playing;
  logic [6:0]           w_idxA, w_idxB;
  logic [2:0]           w_cntA, w_cntB;

  drop_req u_drop_a (
    .clk       (clk),
    .rst       (rst),
    .i_level   (bus.i_dropA),
    .i_service (w_svcA),
    .o_req     (w_reqA)
  );

  drop_req u_drop_b (
    .clk       (clk),
    .rst       (rst),
    .i_level   (bus.i_dropB),
    .i_service (w_svcB),
    .o_req     (w_reqB)
  );

  // Live counts; saturate the wide accumulator into the 3-bit output.
  always_comb begin
    logic [6:0] ca;
    logic [6:0] cb;
    ca = '0;
    cb = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (PLAY_MASK[i] && (r_map0[i] || r_map1[i])) begin
        if (r_owner[i]) cb = cb + 7'd1;
        else            ca = ca + 7'd1;
      end
    end
    w_cntA = (ca > 7'd7) ? 3'd7 : ca[2:0];
    w_cntB = (cb > 7'd7) ? 3'd7 : cb[2:0];
  end

  always_comb begin
    w_svcA    = w_reqA & ~i_tick;
    w_svcB    = w_reqB & ~i_tick;
    w_playing = (bus.game_state == 2'd0);
    w_validA  = coord_ok(bus.playerAx) & coord_ok(bus.playerAy);
    w_validB  = coord_ok(bus.playerBx) & coord_ok(bus.playerBy);
    w_idxA    = w_validA ? cell_idx(bus.playerAx, bus.playerAy) : 7'd0;
    w_idxB    = w_validB ? cell_idx(bus.playerBx, bus.playerBy) : 7'd0;
    w_emptyA  = ~r_map0[w_idxA] & ~r_map1[w_idxA];
    w_emptyB  = ~r_map0[w_idxB] & ~r_map1[w_idxB];
    w_accA    = w_svcA & w_playing & w_validA & w_emptyA & (32'(w_cntA) < MAX_BOMBS);
    // A wins a same-cell collision.
    w_accB    = w_svcB & w_playing & w_validB & w_emptyB & (32'(w_cntB) < MAX_BOMBS)
                & ~(w_accA && (w_idxA == w_idxB));
  end

  always_comb begin
    w_map0_n  = r_map0;
    w_map1_n  = r_map1;
    w_owner_n = r_owner;
    if (i_tick) begin
      w_map0_n = i_updatedBombMap_0 & PLAY_MASK;
      w_map1_n = i_updatedBombMap_1 & PLAY_MASK;
    end else begin
      if (w_accA) begin
        w_map0_n[w_idxA]  = 1'b1;
        w_map1_n[w_idxA]  = 1'b0;
        w_owner_n[w_idxA] = 1'b0;
      end
      if (w_accB) begin
        w_map0_n[w_idxB]  = 1'b1;
        w_map1_n[w_idxB]  = 1'b0;
        w_owner_n[w_idxB] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_map0  <= '0;
      r_map1  <= '0;
      r_owner <= '0;
      r_ackA  <= 1'b0;
      r_ackB  <= 1'b0;
      r_rejA  <= 1'b0;
      r_rejB  <= 1'b0;
    end else begin
      r_map0  <= w_map0_n;
      r_map1  <= w_map1_n;
      r_owner <= w_owner_n;
      r_ackA  <= w_accA;
      r_ackB  <= w_accB;
      r_rejA  <= w_svcA & ~w_accA;
      r_rejB  <= w_svcB & ~w_accB;
    end
  end

  assign o_curBombMap_0   = r_map0;
  assign o_curBombMap_1   = r_map1;
  assign bus.o_bombCountA = w_cntA;
  assign bus.o_bombCountB = w_cntB;
  assign bus.o_placeAckA  = r_ackA;
  assign bus.o_placeAckB  = r_ackB;
  assign bus.o_placeRejA  = r_rejA;
  assign bus.o_placeRejB  = r_rejB;

endmodule
